// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational IM and
// hands each fetched word to decode through a one-entry valid/ready output stage.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 5,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_inst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_out_inst;
    logic [31:0]      r_out_pc;
    logic             r_out_valid;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    logic w_misalign;
    logic w_fault_hit;
    logic w_redir;
    logic w_ld;
    logic w_accept;

    assign w_misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_fault_hit = w_misalign && (r_state != S_FAULT);
    assign w_redir     = redirect_valid && (redirect_pc[1:0] == 2'b00) && (r_state != S_FAULT);
    assign w_ld        = (r_state == S_FETCH) && (!r_out_valid || out_ready);
    assign w_accept    = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect seen in IDLE only moves the PC; fetching starts on a later run cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_misalign) begin
                    w_state_nxt = S_FAULT;
                end else if (w_redir) begin
                    w_state_nxt = S_IDLE;
                end else if (run) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_misalign) begin
                    w_state_nxt = S_FAULT;
                end else if (!run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Priority: misaligned fault, then aligned redirect (flushes the output stage), then load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_out_inst  <= 32'h0000_0000;
            r_out_pc    <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            if (w_fault_hit) begin
                r_fault     <= 1'b1;
                r_out_valid <= 1'b0;
            end else if (w_redir) begin
                r_pc        <= redirect_pc;
                r_out_valid <= 1'b0;
            end else if (w_ld) begin
                r_out_inst  <= im_inst;
                r_out_pc    <= r_pc;
                r_out_valid <= 1'b1;
                r_pc        <= r_pc + 32'd4;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // A word flushed by a redirect in the same cycle is not counted as accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept && !redirect_valid) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign im_addr     = r_pc[IM_AW+1:2];
    assign out_valid   = r_out_valid;
    assign out_inst    = r_out_inst;
    assign out_pc      = r_out_pc;
    assign fault       = r_fault;
    assign busy        = (r_state == S_FETCH);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: cycle-level vector table plus a
// scoreboard of expected accepted PCs popped on every completed handshake.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [4:0]  im_addr;
    logic [31:0] im_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic        busy;
    logic [15:0] fetch_count;

    int errCount;
    int checkCount;
    logic [31:0] sbQ[$];

    typedef struct {
        logic        run;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        expValid;
        logic [31:0] expPc;
        logic [4:0]  expAddr;
        logic [15:0] expCount;
        logic        expBusy;
    } vec_t;

    vec_t vecs[16];

    if_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .IM_AW(5),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .im_addr(im_addr),
        .im_inst(im_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .fault(fault),
        .busy(busy),
        .fetch_count(fetch_count)
    );

    // IM contents: word k holds 0x1000_0000 + k.
    assign im_inst = 32'h1000_0000 + {27'd0, im_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imWord(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h0000_001F);
    endfunction

    function automatic vec_t mkVec(input logic r, input logic rd, input logic rv, input logic [31:0] rpc,
                                   input logic ev, input logic [31:0] epc, input logic [4:0] ea,
                                   input logic [15:0] ec, input logic eb);
        vec_t v;
        v.run = r; v.rdy = rd; v.rv = rv; v.rpc = rpc;
        v.expValid = ev; v.expPc = epc; v.expAddr = ea; v.expCount = ec; v.expBusy = eb;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveCycle(input logic r, input logic rd, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        run            = r;
        out_ready      = rd;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveCycle(v.run, v.rdy, v.rv, v.rpc);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkVal({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v.expValid});
        checkVal({tag, "_im_addr"}, {27'd0, im_addr}, {27'd0, v.expAddr});
        checkVal({tag, "_count"}, {16'd0, fetch_count}, {16'd0, v.expCount});
        checkVal({tag, "_busy"}, {31'd0, busy}, {31'd0, v.expBusy});
        checkVal({tag, "_fault"}, {31'd0, fault}, 32'd0);
        if (v.expValid) begin
            checkVal({tag, "_out_pc"}, out_pc, v.expPc);
            checkVal({tag, "_out_inst"}, out_inst, imWord(v.expPc));
        end
    endtask

    task automatic doReset();
        rst            = 1'b1;
        run            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: each completed, non-flushed handshake must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL sb_underflow: unexpected accept of pc 0x%08h, expected none", out_pc);
            end else begin
                logic [31:0] expPc;
                expPc = sbQ.pop_front();
                checkVal("sb_pc", out_pc, expPc);
                checkVal("sb_inst", out_inst, imWord(expPc));
            end
        end
    end

    initial begin
        bit found;
        errCount   = 0;
        checkCount = 0;

        vecs[0]  = mkVec(1, 1, 0, 32'h0,  0, 32'h00,  0, 0, 0);
        vecs[1]  = mkVec(1, 1, 0, 32'h0,  0, 32'h00,  0, 0, 1);
        vecs[2]  = mkVec(1, 1, 0, 32'h0,  1, 32'h00,  1, 0, 1);
        vecs[3]  = mkVec(1, 1, 0, 32'h0,  1, 32'h04,  2, 1, 1);
        vecs[4]  = mkVec(1, 0, 0, 32'h0,  1, 32'h08,  3, 2, 1);
        vecs[5]  = mkVec(1, 0, 0, 32'h0,  1, 32'h08,  3, 2, 1);
        vecs[6]  = mkVec(1, 0, 0, 32'h0,  1, 32'h08,  3, 2, 1);
        vecs[7]  = mkVec(1, 1, 0, 32'h0,  1, 32'h08,  3, 2, 1);
        vecs[8]  = mkVec(1, 1, 0, 32'h0,  1, 32'h0C,  4, 3, 1);
        vecs[9]  = mkVec(1, 1, 1, 32'h40, 1, 32'h10,  5, 4, 1);
        vecs[10] = mkVec(1, 1, 0, 32'h0,  0, 32'h00, 16, 4, 1);
        vecs[11] = mkVec(1, 1, 0, 32'h0,  1, 32'h40, 17, 4, 1);
        vecs[12] = mkVec(0, 1, 0, 32'h0,  1, 32'h44, 18, 5, 1);
        vecs[13] = mkVec(0, 0, 0, 32'h0,  1, 32'h48, 19, 6, 0);
        vecs[14] = mkVec(0, 1, 0, 32'h0,  1, 32'h48, 19, 6, 0);
        vecs[15] = mkVec(0, 1, 0, 32'h0,  0, 32'h00, 19, 7, 0);

        // Reset state.
        doReset();
        @(negedge clk);
        checkVal("rst_valid", {31'd0, out_valid}, 32'd0);
        checkVal("rst_out_pc", out_pc, 32'h0);
        checkVal("rst_out_inst", out_inst, 32'h0);
        checkVal("rst_fault", {31'd0, fault}, 32'd0);
        checkVal("rst_busy", {31'd0, busy}, 32'd0);
        checkVal("rst_count", {16'd0, fetch_count}, 32'd0);
        checkVal("rst_im_addr", {27'd0, im_addr}, 32'd0);

        // Table: streaming, backpressure at 0x08, flushing redirect to 0x40, stop.
        sbQ.push_back(32'h00); sbQ.push_back(32'h04); sbQ.push_back(32'h08);
        sbQ.push_back(32'h0C); sbQ.push_back(32'h40); sbQ.push_back(32'h44);
        sbQ.push_back(32'h48);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end

        // 32-word stream from reset; fetch_count reaches 32.
        doReset();
        for (int k = 0; k <= 32; k++) sbQ.push_back(32'(k * 4));
        driveCycle(1, 1, 0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (fetch_count == 16'd32) found = 1'b1;
        end
        checkVal("stream_found32", {31'd0, found}, 32'd1);
        checkVal("stream_count", {16'd0, fetch_count}, 32'd32);
        checkVal("stream_next_pc", out_pc, 32'h80);
        checkVal("stream_next_inst", out_inst, 32'h1000_0000);
        driveCycle(0, 0, 0, 32'h0);

        // Wrap: redirect in IDLE to 0x78, then run.
        doReset();
        sbQ.push_back(32'h78); sbQ.push_back(32'h7C); sbQ.push_back(32'h80);
        driveCycle(0, 0, 1, 32'h78);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("wrap_idle_busy", {31'd0, busy}, 32'd0);
        checkVal("wrap_addr0", {27'd0, im_addr}, 32'd30);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("wrap_addr1", {27'd0, im_addr}, 32'd30);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("wrap_pc78", out_pc, 32'h78);
        checkVal("wrap_addr2", {27'd0, im_addr}, 32'd31);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("wrap_pc7c", out_pc, 32'h7C);
        checkVal("wrap_addr3", {27'd0, im_addr}, 32'd0);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("wrap_pc80", out_pc, 32'h80);
        checkVal("wrap_inst80", out_inst, 32'h1000_0000);
        driveCycle(0, 0, 0, 32'h0);

        // Misaligned redirect: sticky fault, no further loads, cleared only by reset.
        doReset();
        driveCycle(0, 0, 1, 32'h20);
        driveCycle(1, 0, 0, 32'h0);
        @(negedge clk);
        checkVal("flt_idle_redir_addr", {27'd0, im_addr}, 32'd8);
        driveCycle(1, 0, 0, 32'h0);
        driveCycle(1, 0, 0, 32'h0);
        @(negedge clk);
        checkVal("flt_pre_pc", out_pc, 32'h20);
        driveCycle(1, 0, 1, 32'h22);
        driveCycle(1, 1, 0, 32'h0);
        @(negedge clk);
        checkVal("flt_fault", {31'd0, fault}, 32'd1);
        checkVal("flt_valid", {31'd0, out_valid}, 32'd0);
        checkVal("flt_busy", {31'd0, busy}, 32'd0);
        checkVal("flt_pc_hold", {27'd0, im_addr}, 32'd9);
        for (int i = 0; i < 3; i++) begin
            driveCycle(1, 1, 0, 32'h0);
            @(negedge clk);
            checkVal("flt_no_load", {31'd0, out_valid}, 32'd0);
            checkVal("flt_sticky", {31'd0, fault}, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        checkVal("flt_rst_fault", {31'd0, fault}, 32'd0);
        checkVal("flt_rst_out_pc", out_pc, 32'h0);
        checkVal("flt_rst_busy", {31'd0, busy}, 32'd0);
        checkVal("flt_rst_addr", {27'd0, im_addr}, 32'd0);

        // Async reset mid-cycle while streaming.
        doReset();
        sbQ.push_back(32'h00); sbQ.push_back(32'h04); sbQ.push_back(32'h08);
        driveCycle(1, 1, 0, 32'h0);
        repeat (5) @(negedge clk);
        checkVal("arst_pre_count", {16'd0, fetch_count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        checkVal("arst_valid", {31'd0, out_valid}, 32'd0);
        checkVal("arst_out_pc", out_pc, 32'h0);
        checkVal("arst_out_inst", out_inst, 32'h0);
        checkVal("arst_busy", {31'd0, busy}, 32'd0);
        checkVal("arst_count", {16'd0, fetch_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.push_back(32'h00);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        checkVal("arst_restart_seen", {31'd0, found}, 32'd1);
        checkVal("arst_first_pc", out_pc, 32'h0);
        driveCycle(0, 0, 0, 32'h0);
        @(negedge clk);

        checkVal("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
